// File: rtl/pattern_scan_pkg.sv
// Shared types and reset defaults for the
// frame-sequenced serial pattern detector.
package pattern_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [7:0] DEF_PATTERN = 8'h0B;
  localparam logic [3:0] DEF_LEN     = 4'd4;

  // Lengths above the history depth collapse onto it.
  function automatic logic [3:0] clamp_len(
    input logic [3:0]  len,
    input int unsigned pmax
  );
    if (int'(len) > int'(pmax)) begin
      return 4'(pmax);
    end
    return len;
  endfunction

endpackage

// File: rtl/pattern_match.sv
// Bit history, valid-bit counter and masked
// compare against the programmed pattern.
module pattern_match
  import pattern_scan_pkg::*;
#(
  parameter int PAT_MAX = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               shift_i,
  input  logic               clear_i,
  input  logic               bit_i,
  input  logic [PAT_MAX-1:0] pattern_i,
  input  logic [3:0]         len_i,
  output logic               det_o
);

  localparam int VW = $clog2(PAT_MAX + 1);

  logic [PAT_MAX-1:0] hist_q, hist_d;
  logic [VW-1:0]      vcnt_q, vcnt_d;
  logic [3:0]         len_c;
  logic [PAT_MAX-1:0] mask_c;

  // Clamped length and the mask of compared bits.
  always_comb begin
    len_c  = clamp_len(len_i, PAT_MAX);
    mask_c = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      mask_c[i] = (i < int'(len_c));
    end
  end

  // Newest bit enters at bit 0; count saturates.
  always_comb begin
    hist_d = hist_q;
    vcnt_d = vcnt_q;
    if (clear_i) begin
      hist_d = '0;
      vcnt_d = '0;
    end else if (shift_i) begin
      hist_d = {hist_q[PAT_MAX-2:0], bit_i};
      if (int'(vcnt_q) < PAT_MAX) begin
        vcnt_d = vcnt_q + VW'(1);
      end
    end
  end

  // History and valid-bit count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
      vcnt_q <= '0;
    end else begin
      hist_q <= hist_d;
      vcnt_q <= vcnt_d;
    end
  end

  // Moore detect: registered history only.
  always_comb begin
    det_o = (len_c != 4'd0)
         && (int'(vcnt_q) >= int'(len_c))
         && (((hist_q ^ pattern_i) & mask_c) == '0);
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Frame controller: word handshake, MSB-first
// serialiser and saturating detection counter.
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int WORD_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_words,
  input  logic               in_valid,
  input  logic [WORD_W-1:0]  in_data,
  output logic               in_ready,
  output logic               det_pulse,
  output logic [CNT_W-1:0]   hit_count,
  output logic               busy,
  output logic               done
);

  localparam int BW = $clog2(WORD_W);

  state_e             state_q, state_d;
  logic [PAT_MAX-1:0] pat_q, pat_d;
  logic [3:0]         len_q, len_d;
  logic [CNT_W-1:0]   words_q, words_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [WORD_W-1:0]  sreg_q, sreg_d;
  logic [CNT_W-1:0]   hit_q, hit_d;
  logic               cnt_en_q, cnt_en_d;
  logic               shift_en;
  logic               clr_hist;
  logic               det;

  pattern_match #(
    .PAT_MAX (PAT_MAX)
  ) u_match (
    .clk_i     (clk),
    .rst_ni    (rst),
    .shift_i   (shift_en),
    .clear_i   (clr_hist),
    .bit_i     (sreg_q[WORD_W-1]),
    .pattern_i (pat_q),
    .len_i     (len_q),
    .det_o     (det)
  );

  // Next-state, datapath and counter updates.
  // cnt_en_q marks the cycle right after a shift,
  // so each shifted bit is counted at most once
  // even while the history is held in a stall.
  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    words_d  = words_q;
    bit_d    = bit_q;
    sreg_d   = sreg_q;
    hit_d    = hit_q;
    cnt_en_d = 1'b0;
    shift_en = 1'b0;
    clr_hist = 1'b0;

    if (cnt_en_q && det && (hit_q != '1)) begin
      hit_d = hit_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          pat_d = cfg_pattern;
          len_d = cfg_len;
        end
        if (start) begin
          words_d  = num_words;
          hit_d    = '0;
          clr_hist = 1'b1;
          if (num_words == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          sreg_d  = in_data;
          words_d = words_q - CNT_W'(1);
          bit_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        cnt_en_d = 1'b1;
        sreg_d   = {sreg_q[WORD_W-2:0], 1'b0};
        if (bit_q == BW'(WORD_W - 1)) begin
          if (words_q != '0) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, config and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pat_q    <= PAT_MAX'(DEF_PATTERN);
      len_q    <= DEF_LEN;
      words_q  <= '0;
      bit_q    <= '0;
      sreg_q   <= '0;
      hit_q    <= '0;
      cnt_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      words_q  <= words_d;
      bit_q    <= bit_d;
      sreg_q   <= sreg_d;
      hit_q    <= hit_d;
      cnt_en_q <= cnt_en_d;
    end
  end

  // Status outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == S_LOAD);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    det_pulse = det;
    hit_count = hit_q;
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: vector table,
// hit-count scoreboard and corner sequences.
module tb_pattern_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       start = 1'b0;
  logic [7:0] num_words = '0;
  logic [1:0] num_words_s;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;

  logic       in_ready, det_pulse, busy, done;
  logic [7:0] hit8;
  logic       in_ready_s, det_s, busy_s, done_s;
  logic [1:0] hit2;

  assign num_words_s = num_words[1:0];

  always #5 clk = ~clk;

  pattern_scan_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .start       (start),
    .num_words   (num_words),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .det_pulse   (det_pulse),
    .hit_count   (hit8),
    .busy        (busy),
    .done        (done)
  );

  pattern_scan_ctrl #(.CNT_W(2)) dut_s (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .start       (start),
    .num_words   (num_words_s),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready_s),
    .det_pulse   (det_s),
    .hit_count   (hit2),
    .busy        (busy_s),
    .done        (done_s)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int unsigned h;
    int unsigned h2;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  typedef struct {
    logic [7:0] pat;
    logic [3:0] len;
    logic [7:0] word;
    logic [7:0] mask;
    int         hits;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Scoreboard: compare final counts on done.
  always @(negedge clk) begin
    if (done) begin
      chk("done_sat_inst", done_s, 1);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_done: hit %0d",
                 hit8);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_hit", hit8, mon_e.h);
        chk("sb_hit_sat", hit2, mon_e.h2);
      end
    end
  end

  task automatic do_cfg(
    input logic [7:0] p,
    input logic [3:0] l
  );
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_pattern = p;
    cfg_len = l;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_start(
    input logic [7:0] n,
    input int unsigned h
  );
    exp_t e;
    e.h  = h;
    e.h2 = (h > 3) ? 3 : h;
    @(negedge clk);
    start = 1'b1;
    num_words = n;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(
    input logic [7:0] w,
    input logic [7:0] m,
    input int         stall
  );
    int n;
    for (int k = 0; k < stall; k++) begin
      chk("stall_ready", in_ready, 1);
      chk("stall_det", det_pulse, 0);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data = w;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("det_bit%0d_w%02h", i, w),
          det_pulse, m[8-i]);
    end
  endtask

  task automatic finish_frame();
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    @(negedge clk);
    chk("done_clear", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time %0t",
             $time);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'h0B, 4'd4,  8'hB0, 8'b0001_0000, 1};
    vecs[1] = '{8'h05, 4'd3,  8'hAA, 8'b0010_1010, 3};
    vecs[2] = '{8'h01, 4'd1,  8'hFF, 8'b1111_1111, 8};
    vecs[3] = '{8'h00, 4'd0,  8'hFF, 8'b0000_0000, 0};
    vecs[4] = '{8'hA5, 4'd12, 8'hA5, 8'b0000_0001, 1};
    vecs[5] = '{8'h00, 4'd4,  8'h00, 8'b0001_1111, 5};

    #2;
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_det", det_pulse, 0);
    chk("rst_hit", hit8, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset-default 1011 pattern, no config write.
    do_start(8'd1, 1);
    send_word(8'hB0, 8'b0001_0000, 0);
    finish_frame();

    for (int v = 0; v < 6; v++) begin
      do_cfg(vecs[v].pat, vecs[v].len);
      do_start(8'd1, vecs[v].hits);
      send_word(vecs[v].word, vecs[v].mask, 0);
      finish_frame();
    end

    // Hit spanning a word boundary, with stall.
    do_cfg(8'h0B, 4'd4);
    do_start(8'd2, 1);
    send_word(8'h01, 8'b0000_0000, 0);
    send_word(8'h60, 8'b0010_0000, 5);
    finish_frame();

    // Empty frame.
    @(negedge clk);
    start = 1'b1;
    num_words = 8'd0;
    exp_q.push_back('{0, 0});
    @(negedge clk);
    start = 1'b0;
    chk("empty_done", done, 1);
    chk("empty_ready", in_ready, 0);
    @(negedge clk);
    chk("empty_idle", busy, 0);
    chk("empty_done_clr", done, 0);

    // Config and start while busy are ignored.
    do_cfg(8'h05, 4'd3);
    do_start(8'd1, 3);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_pattern = 8'h01;
    cfg_len = 4'd1;
    start = 1'b1;
    num_words = 8'd3;
    @(negedge clk);
    cfg_we = 1'b0;
    start = 1'b0;
    send_word(8'hAA, 8'b0010_1010, 0);
    finish_frame();

    // Reset in the middle of a frame.
    do_cfg(8'h01, 4'd1);
    @(negedge clk);
    start = 1'b1;
    num_words = 8'd1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hFF;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_hit", hit8, 2);
    chk("pre_rst_det", det_pulse, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_det", det_pulse, 0);
    chk("mid_rst_hit", hit8, 0);
    chk("mid_rst_hit_sat", hit2, 0);
    @(negedge clk);
    rst = 1'b1;
    do_start(8'd1, 1);
    send_word(8'hB0, 8'b0001_0000, 0);
    finish_frame();

    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
